dmem_responder: RTL and testbench

Multi-cycle, handshaked data-memory responder that services the load/store requests issued by the `cpu` datapath. It accepts one request at a time: `address`, `write_enable`, `read_enable`, `write_data` and `xfer_size` (byte count 1/2/4/8). After a fixed configurable latency it performs the access on a byte-addressed little-endian array and returns a response. It replaces the zero-latency memory model, so the pipelined CPU and stall logic can be exercised against realistic memory timing.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_lane_mask.sv | 27 ++
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   dmem_state_t : responder FSM states (IDLE/WAIT/RESP)
//   XFER_*       : legal transfer sizes in bytes
//   xfer_legal() : true when a size is one of the legal transfer sizes
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [3:0] XFER_B = 4'd1;
  localparam logic [3:0] XFER_H = 4'd2;
  localparam logic [3:0] XFER_W = 4'd4;
  localparam logic [3:0] XFER_D = 4'd8;

  function automatic logic xfer_legal(input logic [3:0] size);
    return (size == XFER_B) || (size == XFER_H) || (size == XFER_W) || (size == XFER_D);
  endfunction

endpackage

// File: rtl/dmem_lane_mask.sv
// dmem_lane_mask: combinational byte-lane decode for one access.
//   i_size      : requested transfer size in bytes
//   i_addr_lo   : low three address bits
//   o_byte_en_c : byte-enable, bit i covers byte addr+i (illegal size -> 8 bytes)
//   o_aligned_c : address is a multiple of the effective size
//   o_legal_c   : size is 1, 2, 4 or 8
module dmem_lane_mask
  import dmem_pkg::*;
(
  input  logic [3:0] i_size,
  input  logic [2:0] i_addr_lo,
  output logic [7:0] o_byte_en_c,
  output logic       o_aligned_c,
  output logic       o_legal_c
);

  logic [3:0] w_eff;

  always_comb begin
    o_legal_c   = xfer_legal(i_size);
    w_eff       = o_legal_c ? i_size : XFER_D;
    o_byte_en_c = 8'((9'd1 << w_eff) - 9'd1);
    // effective size is a power of two, so size-1 masks the misaligned bits
    o_aligned_c = (i_addr_lo & 3'(w_eff - 4'd1)) == 3'd0;
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle handshaked byte-addressed little-endian data memory.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (reject illegal-size / misaligned accesses).
//   clk, rst                : clock, synchronous active-high reset
//   req_valid / req_ready   : request handshake (accept only in IDLE)
//   address, write_enable, read_enable, write_data, xfer_size : request payload
//   resp_valid / resp_ready : response handshake
//   read_data, err          : load result (zero-extended) and reject flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] address,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [63:0] write_data,
  input  logic [3:0]  xfer_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] read_data,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_t r_state;
  dmem_state_t w_state_nxt;
  logic          w_accept;
  logic          w_fire;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic          r_re;
  logic [63:0]   r_wdata;
  logic [3:0]    r_size;
  logic [63:0]   r_read_data;
  logic          r_err;
  logic [7:0]    r_mem [DEPTH];

  logic [7:0]    w_byte_en;
  logic          w_aligned;
  logic          w_legal;
  logic          w_reject;
  logic [63:0]   w_rdata;

  // address bits above the array size are ignored (modulo-DEPTH wrap)
  logic w_unused_addr;
  assign w_unused_addr = ^address[63:AW];

  dmem_lane_mask u_lane_mask (
    .i_size      (r_size),
    .i_addr_lo   (r_addr[2:0]),
    .o_byte_en_c (w_byte_en),
    .o_aligned_c (w_aligned),
    .o_legal_c   (w_legal)
  );

`ifdef DMEM_ALIGN_CHECK_EN
  // only real loads/stores can be rejected; a no-op request never flags err
  assign w_reject = (r_we | r_re) & ~(w_legal & w_aligned);
`else
  logic w_unused_flags;
  assign w_unused_flags = w_aligned ^ w_legal;
  assign w_reject       = 1'b0;
`endif

  assign req_ready  = (r_state == IDLE) && !rst;
  assign resp_valid = (r_state == RESP);
  assign read_data  = r_read_data;
  assign err        = r_err;

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_state_nxt = WAIT;
          w_accept    = 1'b1;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = RESP;
          w_fire      = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // gather addressed bytes, each index wrapping modulo DEPTH
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      if (w_byte_en[i]) w_rdata[8*i +: 8] = r_mem[AW'(r_addr + AW'(i))];
    end
  end

  // FSM state, latched request, latency counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_wdata     <= '0;
      r_size      <= '0;
      r_read_data <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr  <= address[AW-1:0];
        r_we    <= write_enable;
        r_re    <= read_enable;
        r_wdata <= write_data;
        r_size  <= xfer_size;
        r_cnt   <= CW'(LATENCY - 1);
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_fire) begin
        r_read_data <= (r_re && !r_we && !w_reject) ? w_rdata : 64'd0;
        r_err       <= w_reject;
      end
    end
  end

  // byte array: not cleared by reset; a reset on the access edge cancels the store
  always_ff @(posedge clk) begin
    if (!rst && w_fire && r_we && !w_reject) begin
      for (int i = 0; i < 8; i++) begin
        if (w_byte_en[i]) r_mem[AW'(r_addr + AW'(i))] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed + randomized bench for dmem_responder with a
// byte-array reference model. Honours DMEM_ALIGN_CHECK_EN when defined.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] address;
  logic        write_enable;
  logic        read_enable;
  logic [63:0] write_data;
  logic [3:0]  xfer_size;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] read_data;
  logic        err;

  logic [7:0] model [DEPTH];
  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .address      (address),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .write_data   (write_data),
    .xfer_size    (xfer_size),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .read_data    (read_data),
    .err          (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // reference: memory as a plain byte array, little-endian, modulo-DEPTH indices
  task automatic model_op(input logic we, input logic re, input logic [63:0] addr,
                          input logic [63:0] data, input logic [3:0] size,
                          output logic [63:0] rd, output logic e);
    bit legal;
    int n;
    legal = (size == 4'd1) || (size == 4'd2) || (size == 4'd4) || (size == 4'd8);
    n     = legal ? int'(size) : 8;
    rd    = 64'd0;
    e     = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    if ((we || re) && (!legal || ((addr % 64'(size)) != 64'd0))) begin
      e = 1'b1;
      return;
    end
`endif
    if (we) begin
      for (int i = 0; i < n; i++) model[int'((addr + 64'(i)) % 64'(DEPTH))] = data[8*i +: 8];
    end else if (re) begin
      for (int i = 0; i < n; i++) rd[8*i +: 8] = model[int'((addr + 64'(i)) % 64'(DEPTH))];
    end
  endtask

  // one request with resp_ready high: latency, payload and return-to-idle checks
  task automatic do_req(input string tag, input logic we, input logic re,
                        input logic [63:0] addr, input logic [63:0] data,
                        input logic [3:0] size, output logic [63:0] rd_obs);
    logic [63:0] exp_rd;
    logic        exp_e;
    int          cyc;
    req_valid    = 1'b1;
    write_enable = we;
    read_enable  = re;
    address      = addr;
    write_data   = data;
    xfer_size    = size;
    @(posedge clk); #1;
    req_valid = 1'b0;
    model_op(we, re, addr, data, size, exp_rd, exp_e);
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (resp_valid) break;
    end
    chk({tag, ".lat"}, 64'(cyc), 64'(LAT));
    chk({tag, ".rd"}, read_data, exp_rd);
    chk({tag, ".err"}, 64'(err), 64'(exp_e));
    rd_obs = read_data;
    @(posedge clk); #1;
    chk({tag, ".idle"}, 64'({resp_valid, req_ready}), 64'(2'b01));
  endtask

  initial begin
    logic [63:0] rd;
    logic [63:0] exp_rd;
    logic        exp_e;
    logic [3:0]  sz;
    int          cyc;

    rst = 1'b1; req_valid = 1'b0; address = '0; write_enable = 1'b0;
    read_enable = 1'b0; write_data = '0; xfer_size = 4'd8; resp_ready = 1'b1;

    // reset values, with req_valid asserted: reset wins
    req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready", 64'(req_ready), 64'd0);
    chk("rst.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst.read_data", read_data, 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst.release", 64'(req_ready), 64'd1);

    // define the whole array so the model starts known
    for (int k = 0; k < int'(DEPTH / 8); k++)
      do_req("init", 1'b1, 1'b0, 64'(k * 8), {$urandom, $urandom}, 4'd8, rd);

    // doubleword / sub-word / byte merge
    do_req("st_d", 1'b1, 1'b0, 64'd8, 64'h1122334455667788, 4'd8, rd);
    do_req("ld_d", 1'b0, 1'b1, 64'd8, 64'd0, 4'd8, rd);
    chk("ld_d.const", rd, 64'h1122334455667788);
    do_req("ld_h", 1'b0, 1'b1, 64'd10, 64'd0, 4'd2, rd);
    chk("ld_h.const", rd, 64'h0000000000005566);
    do_req("st_b", 1'b1, 1'b0, 64'd9, 64'h00000000000000AB, 4'd1, rd);
    do_req("ld_b", 1'b0, 1'b1, 64'd8, 64'd0, 4'd8, rd);
    chk("ld_b.const", rd, 64'h112233445566AB88);

    // both enables (store, zero data) and no enables (no-op)
    do_req("st_rw", 1'b1, 1'b1, 64'd16, 64'hCAFEF00D12345678, 4'd4, rd);
    do_req("nop", 1'b0, 1'b0, 64'd16, 64'hFFFFFFFFFFFFFFFF, 4'd8, rd);
    do_req("ld_16", 1'b0, 1'b1, 64'd16, 64'd0, 4'd8, rd);

    // backpressure with a second request held on the bus
    resp_ready = 1'b0;
    model_op(1'b0, 1'b1, 64'd8, 64'd0, 4'd8, exp_rd, exp_e);
    req_valid = 1'b1; write_enable = 1'b0; read_enable = 1'b1;
    address = 64'd8; xfer_size = 4'd8; write_data = '0;
    @(posedge clk); #1;
    write_enable = 1'b1; read_enable = 1'b0; write_data = 64'hDEADBEEFDEADBEEF;
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (resp_valid) break;
    end
    chk("bp.lat", 64'(cyc), 64'(LAT));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp.resp_valid", 64'(resp_valid), 64'd1);
      chk("bp.read_data", read_data, exp_rd);
      chk("bp.req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.consume", 64'({resp_valid, req_ready}), 64'(2'b01));
    req_valid = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    chk("bp.no_accept", 64'({resp_valid, req_ready}), 64'(2'b01));
    do_req("bp.reload", 1'b0, 1'b1, 64'd8, 64'd0, 4'd8, rd);

    // reset one cycle after a store is accepted: store discarded
    req_valid = 1'b1; write_enable = 1'b1; read_enable = 1'b0;
    address = 64'd0; write_data = 64'hFFFFFFFFFFFFFFFF; xfer_size = 4'd8;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rw.req_ready", 64'(req_ready), 64'd0);
    chk("rw.resp_valid", 64'(resp_valid), 64'd0);
    chk("rw.read_data", read_data, 64'd0);
    chk("rw.err", 64'(err), 64'd0);
    rst = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    chk("rw.after", 64'({resp_valid, req_ready}), 64'(2'b01));
    do_req("rw.ld0", 1'b0, 1'b1, 64'd0, 64'd0, 4'd8, rd);

    // misaligned, wrap-around and illegal sizes
    do_req("mis.st", 1'b1, 1'b0, 64'd6, {$urandom, $urandom}, 4'd4, rd);
    do_req("mis.ld0", 1'b0, 1'b1, 64'd0, 64'd0, 4'd8, rd);
    do_req("mis.ld8", 1'b0, 1'b1, 64'd8, 64'd0, 4'd8, rd);
    do_req("mis.ld6", 1'b0, 1'b1, 64'd6, 64'd0, 4'd4, rd);
    do_req("wrap.st", 1'b1, 1'b0, 64'(DEPTH - 2), 64'h00000000A1B2C3D4, 4'd4, rd);
    do_req("wrap.ld", 1'b0, 1'b1, 64'(DEPTH - 2), 64'd0, 4'd4, rd);
    do_req("wrap.ld0", 1'b0, 1'b1, 64'd0, 64'd0, 4'd8, rd);
    do_req("wrap.ld56", 1'b0, 1'b1, 64'(DEPTH - 8), 64'd0, 4'd8, rd);
    do_req("ill.ld", 1'b0, 1'b1, 64'd8, 64'd0, 4'd3, rd);
    do_req("ill.st", 1'b1, 1'b0, 64'd24, {$urandom, $urandom}, 4'd0, rd);
    do_req("ill.chk", 1'b0, 1'b1, 64'd24, 64'd0, 4'd8, rd);

    // randomized traffic, full 64-bit addresses
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0: sz = 4'd1;
        1: sz = 4'd2;
        2: sz = 4'd4;
        3: sz = 4'd8;
        default: sz = 4'($urandom_range(0, 15));
      endcase
      do_req("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, {$urandom, $urandom}, sz, rd);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
